// File: rtl/serializer_pkg.sv
// Constants and encoding rules shared by both ends of the serial link
// (serializer on the transmit side, deserializer on the receive side).
package serializer_pkg;

    localparam int DATA_BUS_WIDTH_DEF = 16;
    localparam int DATA_MOD_WIDTH_DEF = $clog2(DATA_BUS_WIDTH_DEF);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } deser_state_t;

    // A word of nbits is reported as nbits; a full-width word wraps to 0.
    function automatic int unsigned mod_encode(input int unsigned nbits,
                                               input int unsigned width);
        return (nbits >= width) ? 0 : nbits;
    endfunction

endpackage

// File: rtl/deserializer_top.sv
// Standalone wrapper: one register stage on every input and every output
// so the deserializer can be timed in isolation.
module deserializer_top
    import serializer_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DATA_BUS_WIDTH_DEF,
    parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      data_i,
    input  logic                      data_val_i,
    input  logic                      data_last_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o
);

    logic                      data_r, val_r, last_r;
    logic [DATA_BUS_WIDTH-1:0] core_data;
    logic [DATA_MOD_WIDTH-1:0] core_mod;
    logic                      core_val, core_busy;

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            data_r           <= 1'b0;
            val_r            <= 1'b0;
            last_r           <= 1'b0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            data_r           <= data_i;
            val_r            <= data_val_i;
            last_r           <= data_last_i;
            deser_data_o     <= core_data;
            deser_data_mod_o <= core_mod;
            deser_data_val_o <= core_val;
            busy_o           <= core_busy;
        end
    end

    deserializer #(
        .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
        .DATA_MOD_WIDTH (DATA_MOD_WIDTH)
    ) u_deserializer (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .data_i           (data_r),
        .data_val_i       (val_r),
        .data_last_i      (last_r),
        .deser_data_o     (core_data),
        .deser_data_mod_o (core_mod),
        .deser_data_val_o (core_val),
        .busy_o           (core_busy)
    );

endmodule

// File: rtl/deserializer.sv
// Collects an MSB-first serial stream into parallel words, with optional
// early termination through data_last_i.
module deserializer
    import serializer_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DATA_BUS_WIDTH_DEF,
    parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      data_i,
    input  logic                      data_val_i,
    input  logic                      data_last_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o
);

    deser_state_t              state, state_nxt;
    logic [DATA_MOD_WIDTH-1:0] cnt, cnt_nxt;
    logic [DATA_MOD_WIDTH-1:0] pos;
    logic [DATA_BUS_WIDTH-1:0] sr, sr_nxt;
    logic [DATA_BUS_WIDTH-1:0] word;
    logic                      done;
    logic [DATA_BUS_WIDTH-1:0] data_nxt;
    logic [DATA_MOD_WIDTH-1:0] mod_nxt;
    logic                      val_nxt;

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            sr               <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            sr               <= sr_nxt;
            deser_data_o     <= data_nxt;
            deser_data_mod_o <= mod_nxt;
            deser_data_val_o <= val_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        data_nxt  = deser_data_o;
        mod_nxt   = deser_data_mod_o;
        val_nxt   = 1'b0;

        // Bit position counts down from the MSB as bits arrive.
        pos       = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1) - cnt;
        word      = sr;
        word[pos] = data_i;
        for (int i = 0; i < DATA_BUS_WIDTH; i++) begin
            if (i < int'(pos)) begin
                word[i] = 1'b0;
            end
        end

        done = data_val_i &&
               ((cnt == DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1)) || data_last_i);

        if (data_val_i) begin
            if (done) begin
                data_nxt  = word;
                mod_nxt   = DATA_MOD_WIDTH'(mod_encode(32'(cnt) + 32'd1,
                                                       DATA_BUS_WIDTH));
                val_nxt   = 1'b1;
                cnt_nxt   = '0;
                sr_nxt    = '0;
                state_nxt = ST_IDLE;
            end else begin
                sr_nxt    = word;
                cnt_nxt   = cnt + DATA_MOD_WIDTH'(1);
                state_nxt = ST_COLLECT;
            end
        end
    end

    assign busy_o = (state == ST_COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed stimulus for deserializer, checked against a
// bit-queue reference model through an expected-word scoreboard.
module tb_deserializer;

    localparam int W  = 16;
    localparam int MW = $clog2(W);

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b0;
    logic          data_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic          data_last_i = 1'b0;
    logic [W-1:0]  deser_data_o;
    logic [MW-1:0] deser_data_mod_o;
    logic          deser_data_val_o;
    logic          busy_o;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [MW-1:0] m;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic          mbits[$];
    logic          m_busy = 1'b0;
    logic [W-1:0]  m_data = '0;
    logic [MW-1:0] m_mod = '0;
    bit            mon_en = 1'b0;
    int            checks = 0;
    int            failures = 0;

    deserializer #(
        .DATA_BUS_WIDTH (W),
        .DATA_MOD_WIDTH (MW)
    ) dut (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .data_last_i      (data_last_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: collect received bits in order; a word is the bits laid
    // out from the MSB down, and its size is reported modulo W.
    task automatic model_step(input logic rst_n, input logic d, input logic v, input logic l);
        logic [W-1:0] w;
        int n;
        if (!rst_n) begin
            mbits.delete();
            m_data = '0;
            m_mod  = '0;
        end else if (v) begin
            mbits.push_back(d);
            n = mbits.size();
            if (n == W || l) begin
                w = '0;
                for (int i = 0; i < n; i++)
                    if (mbits[i]) w[W-1-i] = 1'b1;
                m_data = w;
                m_mod  = MW'(n % W);
                exp_q.push_back('{d: w, m: MW'(n % W)});
                mbits.delete();
            end
        end
        m_busy = (mbits.size() != 0);
    endtask

    task automatic cyc(input logic r, input logic d, input logic v, input logic l);
        #1;
        srst_i      = r;
        data_i      = d;
        data_val_i  = v;
        data_last_i = l;
        @(posedge clk_i);
        model_step(r, d, v, l);
    endtask

    task automatic send_word(input logic [W-1:0] val, input int nbits, input int gap_every,
                             input int gap_len, input bit use_last);
        for (int i = 0; i < nbits; i++) begin
            cyc(1'b1, val[W-1-i], 1'b1, use_last && (i == nbits - 1));
            if (gap_every > 0 && ((i + 1) % gap_every == 0) && i != nbits - 1)
                repeat (gap_len) cyc(1'b1, 1'($urandom), 1'b0, 1'($urandom));
        end
    endtask

    // Every expected word must appear on exactly the negedge after it was
    // pushed, which also pins the one-cycle output latency.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (deser_data_val_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=1 required=0 t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_data", 32'(deser_data_o), 32'(e.d));
                    check("pulse_mod", 32'(deser_data_mod_o), 32'(e.m));
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_pulse actual=0 required=1 data=%0h t=%0t", e.d, $time);
            end
            check("busy", 32'(busy_o), 32'(m_busy));
            check("hold_data", 32'(deser_data_o), 32'(m_data));
            check("hold_mod", 32'(deser_data_mod_o), 32'(m_mod));
        end
    end

    initial begin
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        mon_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        send_word(16'hA5C3, 16, 0, 0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(16'h1234, 16, 4, 3, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(16'hB800, 5, 0, 0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        send_word(16'hFFFF, 16, 0, 0, 1'b0);
        send_word(16'h0001, 16, 0, 0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Partial word discarded by reset; inputs during reset are ignored.
        send_word(16'hFE00, 7, 0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        send_word(16'h8001, 16, 0, 0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        send_word(16'hA000, 3, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        send_word(16'h5A5A, 16, 0, 0, 1'b1);
        repeat (4) cyc(1'b1, 1'($urandom), 1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        repeat (4000) begin
            cyc(1'(($urandom % 250) != 0), 1'($urandom),
                1'(($urandom % 10) < 7), 1'(($urandom % 12) == 0));
        end
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the serializer: collects a 1-bit MSB-first stream qualified by a valid strobe into parallel words of DATA_BUS_WIDTH bits. Emits a one-cycle valid pulse with the assembled word and a bit count in the serializer's data_mod encoding. Supports early termination of a word via a last-bit flag. Sits at the receive end of a serial link, feeding parallel logic.

## Interface
- DATA_BUS_WIDTH, 16, parallel word width (≥ 2).
- DATA_MOD_WIDTH, $clog2(DATA_BUS_WIDTH), width of bit-count field.

- clk_i  input  1  single clock; all logic on posedge.
- srst_i  input  1  synchronous reset, active-low; sampled on posedge clk_i.
- data_i  input  1  serial data bit.
- data_val_i  input  1  data_i valid this cycle.
- data_last_i  input  1  current valid bit is the last bit of the word; ignored when data_val_i = 0.
- deser_data_o  output  DATA_BUS_WIDTH  assembled word; first received bit at bit [DATA_BUS_WIDTH-1].
- deser_data_mod_o  output  DATA_MOD_WIDTH  bits in word; 0 encodes a full DATA_BUS_WIDTH word.
- deser_data_val_o  output  1  one-cycle pulse, deser_data_o/deser_data_mod_o valid.
- busy_o  output  1  partial word held (bit count ≠ 0).

## Operation
- Internal state: shift register sr[DATA_BUS_WIDTH-1:0], bit counter cnt in 0..DATA_BUS_WIDTH-1.
- Two states: IDLE (cnt = 0) and COLLECT (cnt > 0); busy_o = (state == COLLECT).
- Valid bit with data_val_i = 1 writes data_i to sr[DATA_BUS_WIDTH-1-cnt]; other sr bits unchanged.
- Word completes on a valid bit when cnt == DATA_BUS_WIDTH-1 or data_last_i = 1:
  - deser_data_o = sr with the new bit placed; bits below the last received position forced to 0.
  - deser_data_mod_o = cnt+1, with DATA_BUS_WIDTH mapped to 0 (mod-2^DATA_MOD_WIDTH arithmetic).
  - cnt returns to 0, sr cleared, state IDLE.
- Otherwise cnt increments and state moves to or stays in COLLECT.
- data_val_i = 0: no state change. Gaps of any length within a word are allowed.
- data_last_i on a full-width word's final bit: same result as without it; mod = 0.
- data_last_i with data_val_i = 0: ignored; no empty-word pulse is ever generated.
- No backpressure: the consumer must accept every deser_data_val_o pulse.
- deser_data_o and deser_data_mod_o hold their last values between pulses.

## Timing
- Reset (srst_i = 0 at a posedge):
  - deser_data_o = 0, deser_data_mod_o = 0, deser_data_val_o = 0, busy_o = 0.
  - cnt = 0, sr = 0.
  - Reset mid-word discards the partial word silently.
  - Inputs are ignored during reset.
- Latency: deser_data_val_o asserts on the posedge after the cycle carrying the completing bit; all outputs are registered.
- Back-to-back words: a valid bit in the cycle immediately after a completing bit starts the next word at bit [DATA_BUS_WIDTH-1]. Throughput: one word per DATA_BUS_WIDTH valid cycles, no dead cycle.
- busy_o is 1 from the posedge after the first bit of a word until the posedge where the word completes; it is 0 in the same cycle deser_data_val_o = 1.
- Minimum output pulse spacing: 1 cycle, with data_last_i on every bit giving 1-bit words, mod = 1.

## Structure
- Shared package serializer_pkg holds constants common to both link ends:
  - DATA_BUS_WIDTH and DATA_MOD_WIDTH defaults.
  - The mod encoding rule (0 = full word).
  - Parameter values are defaulted from this package.
- No sub-module inside deserializer.
- Companion wrapper deserializer_top registers all inputs and outputs for standalone timing closure. This adds exactly 1 cycle on the input side and 1 cycle on the output side.

## Test plan
- Full word, no gaps: 16 valid bits of 0xA5C3 MSB-first -> one pulse, data = 0xA5C3, mod = 0, 1 cycle after the 16th bit; busy_o high for cycles 2–16.
- Gapped word: 0x1234 sent with data_val_i low for 3 cycles after every 4th bit -> data = 0x1234, mod = 0; no pulse during the gaps.
- Early last: 5 bits 1,0,1,1,1 with data_last_i on the 5th -> data = 0xB800, mod = 5; busy_o = 0 afterwards.
- Back-to-back: 0xFFFF immediately followed by 0x0001 -> two pulses exactly 16 cycles apart, with correct data for each.
- Reset mid-word: 7 bits sent, srst_i low for 1 cycle, then 16 bits of 0x8001 -> single pulse with data = 0x8001; no pulse for the partial word; busy_o = 0 during reset.
- Stray last: data_last_i = 1 with data_val_i = 0 in IDLE and in COLLECT -> no pulse and no counter change.
